mem_port_arbiter: RTL and testbench

//  Shares one 32-bit memory port between two requesters: A = instruction fetch, B = data load/store.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/arb_starve_counter.sv | 35 +++
 rtl/mux2_32.sv | 11 +
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Holds state encodings, mux select polarity and the arbitration rule.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_A = 2'd1,
        ST_BUSY_B = 2'd2
    } state_e;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int CNT_W_DEF        = 3;

    // B has priority on a collision unless A has been passed over too often.
    function automatic logic pick_a(input logic a_req, input logic b_req, input logic at_limit);
        return a_req && (!b_req || at_limit);
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Counts B grants that pass over a pending A request; saturates at STARVE_LIMIT.
module arb_starve_counter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign at_limit = (cnt_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_limit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux2_32.sv
// 2:1 32-bit mux primitive; s=1 passes d1, s=0 passes d0.
module mux2_32 (
    input  logic        s,
    input  logic [31:0] d1,
    input  logic [31:0] d0,
    output logic [31:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between instruction fetch (A) and data (B).
// Grants in IDLE, holds the latched request until mem_ack, then pulses the winner's ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic        a_we,
    output logic        a_ack,
    input  logic        b_req,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic        b_we,
    output logic        b_ack,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    state_e      state_q,     state_d;
    logic        a_ack_q,     a_ack_d;
    logic        b_ack_q,     b_ack_d;
    logic [31:0] rdata_q,     rdata_d;
    logic        sel_q,       sel_d;
    logic        mem_req_q,   mem_req_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q,    mem_we_d;
    logic        busy_q,      busy_d;

    logic        at_limit;
    logic        arb_ok;
    logic        grant;
    logic        win_a;
    logic        win_sel;
    logic        starve_inc;
    logic        starve_clr;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;

    // The ack cycle is already IDLE but must not arbitrate: the acked requester
    // may still be holding its req for that one cycle.
    assign arb_ok     = (state_q == ST_IDLE) && !a_ack_q && !b_ack_q;
    assign win_a      = pick_a(a_req, b_req, at_limit);
    assign win_sel    = win_a ? SEL_A : SEL_B;
    assign grant      = arb_ok && (a_req || b_req);
    assign starve_inc = grant && !win_a && a_req;
    assign starve_clr = arb_ok && (!a_req || win_a);

    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .at_limit (at_limit)
    );

    mux2_32 u_addr_mux (
        .s  (win_sel),
        .d1 (a_addr),
        .d0 (b_addr),
        .y  (win_addr)
    );

    mux2_32 u_wdata_mux (
        .s  (win_sel),
        .d1 (a_wdata),
        .d0 (b_wdata),
        .y  (win_wdata)
    );

    always_comb begin
        state_d     = state_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        rdata_d     = rdata_q;
        sel_d       = sel_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d     = win_a ? ST_BUSY_A : ST_BUSY_B;
                    sel_d       = win_sel;
                    mem_addr_d  = win_addr;
                    mem_wdata_d = win_wdata;
                    mem_we_d    = win_a ? a_we : b_we;
                    mem_req_d   = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            ST_BUSY_A, ST_BUSY_B: begin
                if (mem_ack) begin
                    rdata_d   = mem_rdata;
                    a_ack_d   = (state_q == ST_BUSY_A);
                    b_ack_d   = (state_q == ST_BUSY_B);
                    mem_req_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            rdata_q     <= '0;
            sel_q       <= SEL_B;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            rdata_q     <= rdata_d;
            sel_q       <= sel_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
        end
    end

    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign rdata     = rdata_q;
    assign sel       = sel_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic checked against a rule-level arbitration model.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic        a_req, a_we, a_ack;
    logic [31:0] a_addr, a_wdata;
    logic        b_req, b_we, b_ack;
    logic [31:0] b_addr, b_wdata;
    logic [31:0] rdata;
    logic        sel, mem_req, mem_we, mem_ack, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;
    int starve   = 0;
    logic [31:0] last_rd;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_we      (a_we),
        .a_ack     (a_ack),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_we      (b_we),
        .b_ack     (b_ack),
        .rdata     (rdata),
        .sel       (sel),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Rule-level model: who wins a grant, and how the pass-over count evolves.
    function automatic logic model_grant(input logic a, input logic b);
        logic wa;
        wa = a && (!b || (starve == LIMIT));
        if (wa || !a) starve = 0;
        else if (starve < LIMIT) starve = starve + 1;
        return wa;
    endfunction

    // Waits for the grant, checks payload and hold behaviour, completes with mem_ack.
    // Returns in the ack cycle.
    task automatic serve(input logic exp_a, input int exp_lat, input int waits, input logic [31:0] rd);
        logic [31:0] ea, ew;
        logic        ewe;
        int          n;
        ea  = exp_a ? a_addr  : b_addr;
        ew  = exp_a ? a_wdata : b_wdata;
        ewe = exp_a ? a_we    : b_we;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
            chk("ack_idle", {30'd0, a_ack, b_ack}, 32'd0);
        end
        chk("grant_latency", 32'(n), 32'(exp_lat));
        chk("sel", {31'd0, sel}, {31'd0, exp_a});
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ew);
        chk("mem_we", {31'd0, mem_we}, {31'd0, ewe});
        chk("busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < waits; i++) begin
            tick();
            chk("hold_req", {31'd0, mem_req}, 32'd1);
            chk("hold_sel", {31'd0, sel}, {31'd0, exp_a});
            chk("hold_addr", mem_addr, ea);
            chk("hold_wdata", mem_wdata, ew);
            chk("hold_we", {31'd0, mem_we}, {31'd0, ewe});
            chk("no_early_ack", {30'd0, a_ack, b_ack}, 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        chk("a_ack", {31'd0, a_ack}, {31'd0, exp_a});
        chk("b_ack", {31'd0, b_ack}, {31'd0, !exp_a});
        chk("rdata", rdata, rd);
        chk("req_drop", {31'd0, mem_req}, 32'd0);
        last_rd = rd;
    endtask

    initial begin
        logic exp_order [10];
        logic wa;
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        tick();
        tick();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_sel", {31'd0, sel}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);

        // Reset in the middle of a stalled transfer
        rst_n = 1'b1;
        tick();
        a_req = 1; a_addr = 32'h0000_0100;
        tick();
        chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_sel", {31'd0, sel}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        a_req = 0;
        starve = 0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single zero-wait A read
        a_req = 1; a_addr = 32'h0000_0040; a_wdata = 32'h0; a_we = 0;
        wa = model_grant(1'b1, 1'b0);
        serve(wa, 1, 0, 32'h2402_0005);
        a_req = 0;
        tick();
        chk("a_ack_pulse", {30'd0, a_ack, b_ack}, 32'd0);

        // B write with three memory wait cycles
        b_req = 1; b_addr = 32'h1000_0000; b_wdata = 32'hDEAD_BEEF; b_we = 1;
        wa = model_grant(1'b0, 1'b1);
        serve(wa, 1, 3, 32'h5555_AAAA);
        chk("b_write_we_seen", {31'd0, b_we}, 32'd1);

        // Both held continuously: starvation forcing every fifth grant to A
        a_req = 1; a_addr = 32'hA000_0004; a_wdata = 32'h1111_0000; a_we = 0;
        b_addr = 32'hB000_0008; b_wdata = 32'h2222_0000; b_we = 1;
        for (int i = 0; i < 10; i++) begin
            wa = model_grant(1'b1, 1'b1);
            serve(exp_order[i], 2, i % 3, $urandom);
        end
        a_req = 0; b_req = 0;
        tick();

        // A drops its req mid-transfer; the transfer still completes
        a_req = 1; a_addr = 32'h0000_0200; a_we = 0;
        wa = model_grant(1'b1, 1'b0);
        tick();
        chk("drop_grant_sel", {31'd0, sel}, 32'd1);
        chk("drop_grant_req", {31'd0, mem_req}, 32'd1);
        tick();
        a_req = 0;
        b_req = 1; b_addr = 32'h2000_0010; b_wdata = 32'h0BAD_F00D; b_we = 0;
        chk("drop_hold_req", {31'd0, mem_req}, 32'd1);
        tick();
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 0;
        chk("drop_a_ack", {31'd0, a_ack}, 32'd1);
        chk("drop_b_ack", {31'd0, b_ack}, 32'd0);
        chk("drop_rdata", rdata, 32'h1234_5678);
        last_rd = 32'h1234_5678;
        wa = model_grant(1'b0, 1'b1);
        serve(wa, 2, 1, 32'h8765_4321);
        b_req = 0;
        tick();

        // Stray mem_ack in IDLE, then B rising on A's ack cycle
        mem_ack = 1; mem_rdata = 32'hFFFF_0000;
        tick();
        mem_ack = 0;
        chk("stray_acks", {30'd0, a_ack, b_ack}, 32'd0);
        chk("stray_busy", {31'd0, busy}, 32'd0);
        chk("stray_mem_req", {31'd0, mem_req}, 32'd0);
        chk("stray_rdata", rdata, last_rd);
        a_req = 1; a_addr = 32'h0000_0300; a_we = 1; a_wdata = 32'hCAFE_0001;
        wa = model_grant(1'b1, 1'b0);
        serve(wa, 1, 0, 32'h0000_0007);
        a_req = 0;
        b_req = 1; b_addr = 32'h3000_0000; b_we = 0; b_wdata = 32'h0;
        wa = model_grant(1'b0, 1'b1);
        serve(wa, 2, 0, 32'h0000_0009);

        // Randomized traffic against the model
        for (int r = 0; r < 40; r++) begin
            logic acked_a;
            acked_a = sel;
            if (acked_a || !a_req) begin
                a_req = $urandom_range(0, 1);
                a_addr = $urandom; a_wdata = $urandom; a_we = $urandom_range(0, 1);
            end
            if (!acked_a || !b_req) begin
                b_req = $urandom_range(0, 1);
                b_addr = $urandom; b_wdata = $urandom; b_we = $urandom_range(0, 1);
            end
            if (!a_req && !b_req) begin
                if ($urandom_range(0, 1) == 1) a_req = 1;
                else b_req = 1;
            end
            wa = model_grant(a_req, b_req);
            serve(wa, 2, $urandom_range(0, 3), $urandom);
        end
        a_req = 0; b_req = 0;
        tick();
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
